// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 6;
  localparam int unsigned OP_W      = 3;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [OP_W-1:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2
  } muldiv_state_t;

  // Per-operation context captured at acceptance and consumed in FIXUP.
  typedef struct packed {
    logic is_div;
    logic neg_res;
    logic neg_rem;
    logic div0;
  } muldiv_ctx_t;

endpackage

// File: rtl/hilo_muldiv_if.sv
// CPU-side request/result bus of the HI/LO multiply/divide unit.
interface hilo_muldiv_if
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);

  logic            op_valid;
  logic            op_ready;
  logic [OP_W-1:0] op_code;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;
  logic            done;

  modport master (
    output op_valid, op_code, rs_data, rt_data,
    input  op_ready, hi, lo, busy, done
  );

  modport slave (
    input  op_valid, op_code, rs_data, rt_data,
    output op_ready, hi, lo, busy, done
  );

endinterface

// File: rtl/muldiv_iter_core.sv
// One iteration of shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] shreg_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] acc_nxt_c_o,
  output logic [XLEN-1:0] shreg_nxt_c_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, acc_i} + (shreg_i[0] ? {1'b0, opnd_i} : '0);
    // 33-bit partial remainder; diff[XLEN] set means the trial subtract underflowed
    shifted = {acc_i, shreg_i[XLEN-1]};
    diff    = shifted - {1'b0, opnd_i};
    acc_nxt_c_o   = '0;
    shreg_nxt_c_o = '0;
    if (is_div_i) begin
      if (diff[XLEN]) begin
        acc_nxt_c_o   = shifted[XLEN-1:0];
        shreg_nxt_c_o = {shreg_i[XLEN-2:0], 1'b0};
      end else begin
        acc_nxt_c_o   = diff[XLEN-1:0];
        shreg_nxt_c_o = {shreg_i[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_nxt_c_o   = sum[XLEN:1];
      shreg_nxt_c_o = {sum[0], shreg_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
// Optional FAST_MULT_EN: single-cycle MULT/MULTU through FIXUP; DIV stays iterative.
module hilo_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  hilo_muldiv_if.slave  mif
);

  localparam int unsigned PW = 2 * XLEN;

  muldiv_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] shreg_q, shreg_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  muldiv_ctx_t     ctx_q, ctx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;

  muldiv_op_t      op;
  logic            accept;
  logic            req_div;
  logic            signed_op;
  logic            rs_neg, rt_neg;
  logic [XLEN-1:0] rs_mag, rt_mag;
  logic [XLEN-1:0] acc_step, shreg_step;
  logic [PW-1:0]   prod, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  // Request decode and operand magnitudes for the signed ops.
  assign op        = muldiv_op_t'(mif.op_code);
  assign accept    = mif.op_valid && ready_q;
  assign req_div   = (op == DIV) || (op == DIVU);
  assign signed_op = (op == MULT) || (op == DIV);
  assign rs_neg    = signed_op && mif.rs_data[XLEN-1];
  assign rt_neg    = signed_op && mif.rt_data[XLEN-1];
  assign rs_mag    = rs_neg ? (~mif.rs_data + XLEN'(1)) : mif.rs_data;
  assign rt_mag    = rt_neg ? (~mif.rt_data + XLEN'(1)) : mif.rt_data;

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .is_div_i      (ctx_q.is_div),
    .acc_i         (acc_q),
    .shreg_i       (shreg_q),
    .opnd_i        (opnd_q),
    .acc_nxt_c_o   (acc_step),
    .shreg_nxt_c_o (shreg_step)
  );

  // Sign correction of the finished magnitudes.
  always_comb begin
`ifdef FAST_MULT_EN
    prod = PW'(opnd_q) * PW'(shreg_q);
`else
    prod = {acc_q, shreg_q};
`endif
    prod_fix = ctx_q.neg_res ? (~prod + PW'(1)) : prod;
    quo_fix  = ctx_q.neg_res ? (~shreg_q + XLEN'(1)) : shreg_q;
    rem_fix  = ctx_q.neg_rem ? (~acc_q + XLEN'(1)) : acc_q;
    if (ctx_q.div0) begin
      quo_fix = XLEN'(DIV0_QUOTIENT);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    shreg_d = shreg_q;
    opnd_d  = opnd_q;
    ctx_d   = ctx_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            MTHI: hi_d = mif.rs_data;
            MTLO: lo_d = mif.rs_data;
            MULT, MULTU, DIV, DIVU: begin
              ctx_d.is_div  = req_div;
              ctx_d.neg_res = rs_neg ^ rt_neg;
              ctx_d.neg_rem = rs_neg;
              ctx_d.div0    = req_div && (mif.rt_data == '0);
              cnt_d   = '0;
              acc_d   = '0;
              shreg_d = req_div ? rs_mag : rt_mag;
              opnd_d  = req_div ? rt_mag : rs_mag;
              busy_d  = 1'b1;
              ready_d = 1'b0;
              state_d = ITER;
`ifdef FAST_MULT_EN
              if (!req_div) begin
                state_d = FIXUP;
              end
`endif
            end
            default: ;
          endcase
        end
      end
      ITER: begin
        acc_d   = acc_step;
        shreg_d = shreg_step;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        if (ctx_q.is_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[PW-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      shreg_q <= '0;
      opnd_q  <= '0;
      ctx_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      shreg_q <= shreg_d;
      opnd_q  <= opnd_d;
      ctx_q   <= ctx_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign mif.op_ready = ready_q;
  assign mif.hi       = hi_q;
  assign mif.lo       = lo_q;
  assign mif.busy     = busy_q;
  assign mif.done     = done_q;

endmodule
